// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant among ALU, load and
// mul/div result ports, a one-cycle registered write port, and a pending
// bitmap of outstanding destinations for source hazard checks.
module rf_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 req_valid,
    input  logic [3*ADDR_WIDTH-1:0]    req_waddr,
    input  logic [3*DATA_WIDTH-1:0]    req_wdata,
    output logic [2:0]                 req_ready,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    input  logic                       iss_valid,
    input  logic [ADDR_WIDTH-1:0]      iss_waddr,
    input  logic [ADDR_WIDTH-1:0]      chk_raddr1,
    input  logic [ADDR_WIDTH-1:0]      chk_raddr2,
    output logic                       chk_busy1,
    output logic                       chk_busy2
);

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    logic [1:0]            ptr;
    logic [1:0]            ptr_next;
    logic [1:0]            cand;
    logic                  grant_any;
    logic [1:0]            grant_idx;
    logic [ADDR_WIDTH-1:0] grant_waddr;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;

    // Round-robin search starting at ptr; no grant is ever issued in reset.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 2'((32'(ptr) + k) % NUM_REQ);
            if (rst_n && !grant_any && req_valid[cand]) begin
                grant_any       = 1'b1;
                grant_idx       = cand;
                req_ready[cand] = 1'b1;
            end
        end
        grant_waddr = req_waddr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        grant_wdata = req_wdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        ptr_next    = ptr;
        if (grant_any) begin
            ptr_next = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    // Pending bitmap update: clear on acceptance, then set on issue so set wins.
    always_comb begin
        pending_next = pending;
        if (grant_any) begin
            pending_next[grant_waddr] = 1'b0;
        end
        if (iss_valid) begin
            pending_next[iss_waddr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Hazard lookup against the registered bitmap; x0 is never busy.
    always_comb begin
        chk_busy1 = (chk_raddr1 != '0) && pending[chk_raddr1];
        chk_busy2 = (chk_raddr2 != '0) && pending[chk_raddr2];
    end

    // State and write-port registers; address/data hold when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'd0;
            pending  <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            ptr     <= ptr_next;
            pending <= pending_next;
            rf_wen  <= grant_any && (grant_waddr != '0);
            if (grant_any) begin
                rf_waddr <= grant_waddr;
                rf_wdata <= grant_wdata;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, write-port latency,
// pending bitmap behaviour and asynchronous reset.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_waddr;
    logic [95:0] req_wdata;
    logic [2:0]  req_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic [4:0]  chk_raddr1;
    logic [4:0]  chk_raddr2;
    logic        chk_busy1;
    logic        chk_busy2;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_waddr  (req_waddr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .iss_valid  (iss_valid),
        .iss_waddr  (iss_waddr),
        .chk_raddr1 (chk_raddr1),
        .chk_raddr2 (chk_raddr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 3'b111;
        req_waddr  = {5'd3, 5'd2, 5'd1};
        req_wdata  = {32'h33333333, 32'h22222222, 32'h11111111};
        iss_valid  = 1'b0;
        iss_waddr  = 5'd0;
        chk_raddr1 = 5'd1;
        chk_raddr2 = 5'd2;
        tick();
        tick();

        // Reset state, with all requesters valid.
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_wen",   64'(rf_wen),    64'h0);
        check("rst_waddr", 64'(rf_waddr),  64'h0);
        check("rst_wdata", 64'(rf_wdata),  64'h0);
        check("rst_busy1", 64'(chk_busy1), 64'h0);

        // All three valid: grants 0,1,2 on consecutive cycles.
        rst_n = 1'b1;
        #1;
        check("rr_ready0", 64'(req_ready), 64'h1);
        tick();
        check("rr_wen1",   64'(rf_wen),    64'h1);
        check("rr_waddr1", 64'(rf_waddr),  64'd1);
        check("rr_wdata1", 64'(rf_wdata),  64'h11111111);
        check("rr_ready1", 64'(req_ready), 64'h2);
        tick();
        check("rr_waddr2", 64'(rf_waddr),  64'd2);
        check("rr_wdata2", 64'(rf_wdata),  64'h22222222);
        check("rr_ready2", 64'(req_ready), 64'h4);
        tick();
        check("rr_wen3",   64'(rf_wen),    64'h1);
        check("rr_waddr3", 64'(rf_waddr),  64'd3);
        check("rr_wdata3", 64'(rf_wdata),  64'h33333333);
        check("rr_wrap",   64'(req_ready), 64'h1);

        // No request: ready low, wen drops, address/data hold.
        req_valid = 3'b000;
        #1;
        check("idle_ready", 64'(req_ready), 64'h0);
        tick();
        check("idle_wen",   64'(rf_wen),    64'h0);
        check("idle_waddr", 64'(rf_waddr),  64'd3);
        check("idle_wdata", 64'(rf_wdata),  64'h33333333);

        // Lone mul/div request.
        req_valid = 3'b100;
        req_waddr = {5'd7, 5'd2, 5'd1};
        req_wdata = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
        #1;
        check("md_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 3'b000;
        check("md_wen",   64'(rf_wen),   64'h1);
        check("md_waddr", 64'(rf_waddr), 64'd7);
        check("md_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        req_valid = 3'b111;
        #1;
        check("md_ptr0", 64'(req_ready), 64'h1);

        // Pointer 0, requesters 1,2 valid -> 1; then pointer 2, requesters 0,1 -> 0.
        req_valid = 3'b110;
        #1;
        check("rr_skip0", 64'(req_ready), 64'h2);
        tick();
        req_valid = 3'b011;
        #1;
        check("rr_from2", 64'(req_ready), 64'h1);
        tick();
        req_valid = 3'b000;

        // Issue to x5 becomes visible next cycle, cleared by a write to x5.
        iss_valid  = 1'b1;
        iss_waddr  = 5'd5;
        chk_raddr1 = 5'd5;
        #1;
        check("iss5_same", 64'(chk_busy1), 64'h0);
        tick();
        iss_valid = 1'b0;
        check("iss5_busy", 64'(chk_busy1), 64'h1);
        req_valid = 3'b001;
        req_waddr = {5'd7, 5'd2, 5'd5};
        req_wdata = {32'hDEADBEEF, 32'h22222222, 32'h00000055};
        #1;
        check("wr5_ready", 64'(req_ready), 64'h1);
        check("wr5_still", 64'(chk_busy1), 64'h1);
        tick();
        req_valid = 3'b000;
        #1;
        check("wr5_clear", 64'(chk_busy1), 64'h0);
        check("wr5_waddr", 64'(rf_waddr),  64'd5);

        // Same-cycle issue and acceptance on x9: set wins.
        chk_raddr2 = 5'd9;
        req_valid  = 3'b010;
        req_waddr  = {5'd7, 5'd9, 5'd5};
        iss_valid  = 1'b1;
        iss_waddr  = 5'd9;
        #1;
        check("x9_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 3'b000;
        iss_valid = 1'b0;
        #1;
        check("x9_busy", 64'(chk_busy2), 64'h1);
        check("x9_wen",  64'(rf_wen),    64'h1);

        // Write to x0 (and issue to x0): accepted, no write, never busy.
        req_valid  = 3'b100;
        req_waddr  = {5'd0, 5'd9, 5'd5};
        iss_valid  = 1'b1;
        iss_waddr  = 5'd0;
        chk_raddr1 = 5'd0;
        #1;
        check("x0_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 3'b000;
        iss_valid = 1'b0;
        #1;
        check("x0_wen",  64'(rf_wen),    64'h0);
        check("x0_busy", 64'(chk_busy1), 64'h0);
        req_valid = 3'b111;
        #1;
        check("x0_ptr", 64'(req_ready), 64'h1);

        // Reset mid-operation with a registered write and x3 pending.
        req_valid  = 3'b000;
        iss_valid  = 1'b1;
        iss_waddr  = 5'd3;
        chk_raddr1 = 5'd3;
        tick();
        iss_valid = 1'b0;
        check("x3_busy", 64'(chk_busy1), 64'h1);
        req_valid = 3'b010;
        req_waddr = {5'd0, 5'd4, 5'd5};
        tick();
        req_valid = 3'b000;
        check("pre_rst_wen", 64'(rf_wen), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wen",   64'(rf_wen),    64'h0);
        check("mid_rst_waddr", 64'(rf_waddr),  64'h0);
        check("mid_rst_busy",  64'(chk_busy1), 64'h0);
        rst_n = 1'b1;
        req_valid = 3'b111;
        #1;
        check("post_rst_ptr", 64'(req_ready), 64'h1);
        tick();
        req_valid = 3'b000;
        check("post_rst_waddr", 64'(rf_waddr), 64'd5);
        check("post_rst_wdata", 64'(rf_wdata), 64'h00000055);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register address width; 2**ADDR_WIDTH registers.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  3  per-requester write request (bit 0 = ALU, bit 1 = load, bit 2 = mul/div).
REQ-006 SHALL have port req_waddr  input  3*ADDR_WIDTH  packed destination addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 SHALL have port req_wdata  input  3*DATA_WIDTH  packed write data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  3  one-hot-or-zero grant; transfer on req_valid[i] & req_ready[i].
REQ-009 SHALL have port rf_wen  output  1  register-file write enable, registered.
REQ-010 SHALL have port rf_waddr  output  ADDR_WIDTH  register-file write address, registered.
REQ-011 SHALL have port rf_wdata  output  DATA_WIDTH  register-file write data, registered.
REQ-012 SHALL have port iss_valid  input  1  issue strobe: a write to iss_waddr is now outstanding.
REQ-013 SHALL have port iss_waddr  input  ADDR_WIDTH  destination of the issued instruction.
REQ-014 SHALL have ports chk_raddr1 and chk_raddr2  input  ADDR_WIDTH each  source addresses to hazard-check.
REQ-015 SHALL have ports chk_busy1 and chk_busy2  output  1 each  source register has an outstanding write.

Function
REQ-016 SHALL grant at most one requester per cycle; req_ready SHALL be combinational from req_valid and the priority pointer.
REQ-017 SHALL arbitrate round-robin: the 2-bit pointer ptr (0..2) names the highest-priority requester, and the search runs ptr, ptr+1, ptr+2, each mod 3.
REQ-018 SHALL set ptr to (granted index + 1) mod 3 after a grant, and hold ptr when no grant occurs.
REQ-019 SHALL deassert req_ready[i] whenever req_valid[i]=0.
REQ-020 SHALL require a requester to hold valid, address and data stable until ready; the block does not buffer ungranted requests.
REQ-021 SHALL register an accepted transfer so that rf_wen=1, rf_waddr and rf_wdata appear in the cycle following the handshake; latency is exactly 1 cycle.
REQ-022 SHALL drive rf_wen=0 in the cycle after a no-grant cycle; rf_waddr and rf_wdata SHALL hold their previous values.
REQ-023 SHALL accept a request with waddr=0 normally (ready asserted, pointer advanced) but drive rf_wen=0 for it.
REQ-024 SHALL keep a pending vector of 2**ADDR_WIDTH bits: set bit iss_waddr on iss_valid, and clear bit waddr on handshake acceptance.
REQ-025 SHALL treat simultaneous set and clear of the same bit as set-wins, so the bit ends at 1.
REQ-026 SHALL leave an already-pending bit at 1 on re-issue to the same register; there is no counting.
REQ-027 SHALL never set pending bit 0, and SHALL drive chk_busy=0 for address 0.
REQ-028 SHALL compute chk_busy1 and chk_busy2 combinationally from the registered pending vector; a same-cycle issue is visible next cycle.
REQ-029 SHALL ignore an acceptance for a register whose pending bit is already 0; no error is raised.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force rf_wen=0, rf_waddr=0, rf_wdata=0, ptr=0 and all pending bits to 0.
REQ-031 SHALL hold req_ready=0 while rst_n=0.
REQ-032 SHALL discard, on reset mid-operation, any in-flight registered write and all pending state; the first grant after release SHALL go to requester 0 if it is valid.

Verification
REQ-033 SHALL cover: reset release, then req_valid=3'b111 held for 3 cycles with fixed payloads -> grants 0,1,2 on consecutive cycles; rf_wen=1 on cycles 1-3 with matching waddr/wdata.
REQ-034 SHALL cover: req_valid=3'b100 only, waddr=7, wdata=32'hDEADBEEF -> ready[2]=1 that cycle; next cycle rf_wen=1, rf_waddr=7, rf_wdata=32'hDEADBEEF; ptr becomes 0.
REQ-035 SHALL cover: iss_valid with waddr=5, then chk_raddr1=5 -> chk_busy1=1 from the next cycle; after an accepted write to 5, chk_busy1=0 the following cycle.
REQ-036 SHALL cover: same-cycle iss_valid to 9 and accepted write to 9 -> pending[9]=1 afterwards.
REQ-037 SHALL cover: request with waddr=0 -> ready asserted, rf_wen=0 next cycle, ptr advanced; chk_raddr=0 -> busy=0.
REQ-038 SHALL cover: rst_n pulsed low while a grant is registered and pending[3]=1 -> rf_wen=0 immediately, pending cleared, ptr=0.
